// File: rtl/ddr3_port_arbiter_if.sv
// Bus bundle for the DDR3 port arbiter: M0/M1 Avalon-MM command/response and the shared DDR3 port.
// The slave modport is the arbiter's view; the master modport is the masters' and memory's view.
interface ddr3_port_arbiter_if #(
  parameter int ADDR_W  = 29,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 8
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0]  m0_address;
  logic               m0_read;
  logic               m0_write;
  logic [DATA_W-1:0]  m0_writedata;
  logic [BE_W-1:0]    m0_byteenable;
  logic               m0_waitrequest;
  logic [DATA_W-1:0]  m0_readdata;
  logic               m0_readdatavalid;

  logic [ADDR_W-1:0]  m1_address;
  logic [BURST_W-1:0] m1_burstcount;
  logic               m1_read;
  logic               m1_urgent;
  logic               m1_waitrequest;
  logic [DATA_W-1:0]  m1_readdata;
  logic               m1_readdatavalid;

  logic [ADDR_W-1:0]  ddr3_addr;
  logic [BURST_W-1:0] ddr3_burstcnt;
  logic               ddr3_read;
  logic               ddr3_write;
  logic [DATA_W-1:0]  ddr3_writedata;
  logic [BE_W-1:0]    ddr3_byteenable;
  logic [DATA_W-1:0]  ddr3_readdata;
  logic               ddr3_readdatavalid;
  logic               ddr3_waitrequest;

  modport slave (
    input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_burstcount, m1_read, m1_urgent,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output ddr3_addr, ddr3_burstcnt, ddr3_read, ddr3_write, ddr3_writedata, ddr3_byteenable,
    input  ddr3_readdata, ddr3_readdatavalid, ddr3_waitrequest
  );

  modport master (
    output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_burstcount, m1_read, m1_urgent,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  ddr3_addr, ddr3_burstcnt, ddr3_read, ddr3_write, ddr3_writedata, ddr3_byteenable,
    output ddr3_readdata, ddr3_readdatavalid, ddr3_waitrequest
  );
endinterface

// File: rtl/ddr3_port_arbiter.sv
// Two-master arbiter for one DDR3 Avalon-MM port with in-order read-beat routing via a tag FIFO.
// Optional grant/stall counters are built when ARB_STATS_EN is defined.
module ddr3_port_arbiter #(
  parameter int ADDR_W    = 29,
  parameter int DATA_W    = 64,
  parameter int BURST_W   = 8,
  parameter int TAG_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ddr3_port_arbiter_if.slave  bus,
  output logic                rd_orphan_o,
  output logic [31:0]         stat_m0_grants_o,
  output logic [31:0]         stat_m1_grants_o,
  output logic [31:0]         stat_war_stalls_o
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]     PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_e;
  typedef struct packed {
    logic               id;
    logic [BURST_W-1:0] burst;
  } tag_t;

  state_e              state_q, state_d;
  logic                last_m1_q, last_m1_d;
  logic                m0_wait_q, m0_wait_d, m1_wait_q, m1_wait_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;

  tag_t                fifo_mem [TAG_DEPTH];
  logic [PTR_W:0]      wr_ptr_q, rd_ptr_q, fill_s;
  logic [BURST_W-1:0]  beat_q;
  logic                orphan_q;
  logic                fifo_empty_s, fifo_full_s, push_s, pop_s, beat_s;
  tag_t                push_tag_s, head_s;
  logic                wr_ok_s, rd_ok_s, m0_req_s, m1_req_s, any_req_s, m1_wins_s;

  assign fill_s       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty_s = (fill_s == {(PTR_W+1){1'b0}});
  assign fifo_full_s  = fill_s[PTR_W];
  assign head_s       = fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign beat_s       = bus.ddr3_readdatavalid & ~fifo_empty_s;
  assign pop_s        = beat_s & ((beat_q + BURST_ONE) == head_s.burst);

  // A pending M0 write blocks every read so outstanding reads can drain before it issues.
  assign wr_ok_s   = fifo_empty_s & (beat_q == {BURST_W{1'b0}});
  assign rd_ok_s   = ~fifo_full_s & ~bus.m0_write;
  assign m0_req_s  = (bus.m0_write & wr_ok_s) | (bus.m0_read & rd_ok_s);
  assign m1_req_s  = bus.m1_read & rd_ok_s;
  assign any_req_s = m0_req_s | m1_req_s;

  // Winner selection: urgent M1 first, otherwise alternate against the last grant.
  always_comb begin
    m1_wins_s = 1'b0;
    if (!m1_req_s) begin
      m1_wins_s = 1'b0;
    end else if (!m0_req_s || bus.m1_urgent) begin
      m1_wins_s = 1'b1;
    end else begin
      m1_wins_s = ~last_m1_q;
    end
  end

  // Command FSM next state: capture the winner's command, hold it until the DDR3 port accepts.
  always_comb begin
    state_d    = state_q;
    last_m1_d  = last_m1_q;
    m0_wait_d  = 1'b1;
    m1_wait_d  = 1'b1;
    addr_d     = addr_q;
    burst_d    = burst_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    push_s     = 1'b0;
    push_tag_s = {1'b0, {BURST_W{1'b0}}};
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d = ISSUE;
          if (m1_wins_s) begin
            m1_wait_d  = 1'b0;
            last_m1_d  = 1'b1;
            addr_d     = bus.m1_address;
            burst_d    = bus.m1_burstcount;
            rd_d       = 1'b1;
            wr_d       = 1'b0;
            be_d       = {BE_W{1'b1}};
            push_s     = 1'b1;
            push_tag_s = {1'b1, bus.m1_burstcount};
          end else begin
            m0_wait_d  = 1'b0;
            last_m1_d  = 1'b0;
            addr_d     = bus.m0_address;
            burst_d    = BURST_ONE;
            rd_d       = bus.m0_read;
            wr_d       = bus.m0_write;
            wdata_d    = bus.m0_writedata;
            be_d       = bus.m0_write ? bus.m0_byteenable : {BE_W{1'b1}};
            push_s     = bus.m0_read;
            push_tag_s = {1'b0, BURST_ONE};
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (!bus.ddr3_waitrequest) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered DDR3 command / master waitrequests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_m1_q <= 1'b1;
      m0_wait_q <= 1'b1;
      m1_wait_q <= 1'b1;
      addr_q    <= {ADDR_W{1'b0}};
      burst_q   <= BURST_ONE;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= {DATA_W{1'b0}};
      be_q      <= {BE_W{1'b0}};
    end else begin
      state_q   <= state_d;
      last_m1_q <= last_m1_d;
      m0_wait_q <= m0_wait_d;
      m1_wait_q <= m1_wait_d;
      addr_q    <= addr_d;
      burst_q   <= burst_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
    end
  end

  // Tag FIFO storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_tag_s;
    end
  end

  // Tag FIFO pointers, beat counter for the head burst, sticky orphan flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {(PTR_W+1){1'b0}};
      rd_ptr_q <= {(PTR_W+1){1'b0}};
      beat_q   <= {BURST_W{1'b0}};
      orphan_q <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (beat_s) beat_q   <= pop_s ? {BURST_W{1'b0}} : beat_q + BURST_ONE;
      if (bus.ddr3_readdatavalid && fifo_empty_s) orphan_q <= 1'b1;
    end
  end

  assign bus.m0_waitrequest   = m0_wait_q;
  assign bus.m1_waitrequest   = m1_wait_q;
  assign bus.ddr3_addr        = addr_q;
  assign bus.ddr3_burstcnt    = burst_q;
  assign bus.ddr3_read        = rd_q;
  assign bus.ddr3_write       = wr_q;
  assign bus.ddr3_writedata   = wdata_q;
  assign bus.ddr3_byteenable  = be_q;
  assign bus.m0_readdatavalid = beat_s & ~head_s.id;
  assign bus.m1_readdatavalid = beat_s & head_s.id;
  assign bus.m0_readdata      = bus.m0_readdatavalid ? bus.ddr3_readdata : {DATA_W{1'b0}};
  assign bus.m1_readdata      = bus.m1_readdatavalid ? bus.ddr3_readdata : {DATA_W{1'b0}};
  assign rd_orphan_o          = orphan_q;

`ifdef ARB_STATS_EN
  logic        gnt_m0_s, gnt_m1_s, drain_s;
  logic [31:0] m0_cnt_q, m1_cnt_q, war_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign gnt_m0_s = (state_q == IDLE) & any_req_s & ~m1_wins_s;
  assign gnt_m1_s = (state_q == IDLE) & any_req_s & m1_wins_s;
  assign drain_s  = bus.m0_write & ~wr_ok_s;

  // Saturating grant and write-after-read stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_cnt_q  <= 32'd0;
      m1_cnt_q  <= 32'd0;
      war_cnt_q <= 32'd0;
    end else begin
      if (gnt_m0_s) m0_cnt_q  <= sat_inc(m0_cnt_q);
      if (gnt_m1_s) m1_cnt_q  <= sat_inc(m1_cnt_q);
      if (drain_s)  war_cnt_q <= sat_inc(war_cnt_q);
    end
  end

  assign stat_m0_grants_o  = m0_cnt_q;
  assign stat_m1_grants_o  = m1_cnt_q;
  assign stat_war_stalls_o = war_cnt_q;
`else
  assign stat_m0_grants_o  = 32'd0;
  assign stat_m1_grants_o  = 32'd0;
  assign stat_war_stalls_o = 32'd0;
`endif
endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: vector table for single commands plus arbitration,
// write-after-read, FIFO-full and reset-orphan sequences.
module tb_ddr3_port_arbiter;
  localparam int AW = 29;
  localparam int DW = 64;
  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_orphan;
  logic [31:0] st_m0, st_m1, st_war;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  ddr3_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) bus ();

  ddr3_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .TAG_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .rd_orphan_o(rd_orphan),
    .stat_m0_grants_o(st_m0), .stat_m1_grants_o(st_m1), .stat_war_stalls_o(st_war)
  );

  typedef struct {
    bit         m1;
    bit         rd;
    bit         wr;
    logic [28:0] addr;
    logic [7:0]  burst;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [28:0] x_addr;
    logic [7:0]  x_burst;
    bit         x_rd;
    bit         x_wr;
    logic [7:0]  x_be;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_address = '0; bus.m0_read = 1'b0; bus.m0_write = 1'b0;
    bus.m0_writedata = '0; bus.m0_byteenable = '0;
    bus.m1_address = '0; bus.m1_burstcount = 8'd1; bus.m1_read = 1'b0; bus.m1_urgent = 1'b0;
    bus.ddr3_readdata = '0; bus.ddr3_readdatavalid = 1'b0; bus.ddr3_waitrequest = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_grant(input bit m1, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (m1 ? !bus.m1_waitrequest : !bus.m0_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Returns valid-strobe counts per port and count of valid beats carrying wrong data.
  task automatic deliver(input int n, output int c0, output int c1, output int dbad);
    logic [63:0] d;
    c0 = 0; c1 = 0; dbad = 0;
    for (int b = 0; b < n; b++) begin
      d = 64'hC0DE_0000_0000_0000 + 64'(b);
      bus.ddr3_readdata = d;
      bus.ddr3_readdatavalid = 1'b1;
      #1;
      if (bus.m0_readdatavalid) begin
        c0++;
        if (bus.m0_readdata !== d) dbad++;
      end
      if (bus.m1_readdatavalid) begin
        c1++;
        if (bus.m1_readdata !== d) dbad++;
      end
      tick();
    end
    bus.ddr3_readdatavalid = 1'b0;
  endtask

  initial begin
    bit ok;
    int c0, c1, dbad, g, both, viol;
    logic seq [10];
    vec_t v;

    vt[0] = '{m1:1'b0, rd:1'b0, wr:1'b1, addr:29'h0123456, burst:8'd0, wdata:64'h0000_0000_DEAD_BEEF,
              be:8'hFF, x_addr:29'h0123456, x_burst:8'd1, x_rd:1'b0, x_wr:1'b1, x_be:8'hFF};
    vt[1] = '{m1:1'b0, rd:1'b1, wr:1'b0, addr:29'h0002000, burst:8'd5, wdata:64'h0,
              be:8'h3C, x_addr:29'h0002000, x_burst:8'd1, x_rd:1'b1, x_wr:1'b0, x_be:8'hFF};
    vt[2] = '{m1:1'b1, rd:1'b1, wr:1'b0, addr:29'h0001000, burst:8'd8, wdata:64'h0,
              be:8'h00, x_addr:29'h0001000, x_burst:8'd8, x_rd:1'b1, x_wr:1'b0, x_be:8'hFF};
    vt[3] = '{m1:1'b1, rd:1'b1, wr:1'b0, addr:29'h1FFFFFFF, burst:8'd255, wdata:64'h0,
              be:8'h00, x_addr:29'h1FFFFFFF, x_burst:8'd255, x_rd:1'b1, x_wr:1'b0, x_be:8'hFF};
    vt[4] = '{m1:1'b0, rd:1'b0, wr:1'b1, addr:29'h0000000, burst:8'd0, wdata:64'h0123_4567_89AB_CDEF,
              be:8'h0F, x_addr:29'h0000000, x_burst:8'd1, x_rd:1'b0, x_wr:1'b1, x_be:8'h0F};
    vt[5] = '{m1:1'b0, rd:1'b1, wr:1'b0, addr:29'h1FFFFFFF, burst:8'd0, wdata:64'h0,
              be:8'hFF, x_addr:29'h1FFFFFFF, x_burst:8'd1, x_rd:1'b1, x_wr:1'b0, x_be:8'hFF};

    // Reset state
    do_reset();
    chk("rst_m0_wait", bus.m0_waitrequest, 1);
    chk("rst_m1_wait", bus.m1_waitrequest, 1);
    chk("rst_rdwr", {bus.ddr3_read, bus.ddr3_write}, 0);
    chk("rst_addr", bus.ddr3_addr, 0);
    chk("rst_burst", bus.ddr3_burstcnt, 1);
    chk("rst_wdata", bus.ddr3_writedata, 0);
    chk("rst_valids", {bus.m0_readdatavalid, bus.m1_readdatavalid}, 0);
    chk("rst_orphan", rd_orphan, 0);
    chk("rst_stats", {st_m0, st_m1} | 64'(st_war), 0);

    // Single-command vectors
    for (int i = 0; i < 6; i++) begin
      v = vt[i];
      if (v.m1) begin
        bus.m1_address = v.addr; bus.m1_burstcount = v.burst; bus.m1_read = 1'b1;
      end else begin
        bus.m0_address = v.addr; bus.m0_read = v.rd; bus.m0_write = v.wr;
        bus.m0_writedata = v.wdata; bus.m0_byteenable = v.be; bus.m1_burstcount = v.burst;
      end
      wait_grant(v.m1, 10, ok);
      chk($sformatf("v%0d_grant", i), ok, 1);
      chk($sformatf("v%0d_addr", i), bus.ddr3_addr, v.x_addr);
      chk($sformatf("v%0d_burst", i), bus.ddr3_burstcnt, v.x_burst);
      chk($sformatf("v%0d_rdwr", i), {bus.ddr3_read, bus.ddr3_write}, {v.x_rd, v.x_wr});
      chk($sformatf("v%0d_be", i), bus.ddr3_byteenable, v.x_be);
      if (v.x_wr) chk($sformatf("v%0d_wdata", i), bus.ddr3_writedata, v.wdata);
      bus.m0_read = 1'b0; bus.m0_write = 1'b0; bus.m1_read = 1'b0;
      tick();
      chk($sformatf("v%0d_wait_1cyc", i), v.m1 ? bus.m1_waitrequest : bus.m0_waitrequest, 1);
      chk($sformatf("v%0d_hold", i), {bus.ddr3_read, bus.ddr3_write, bus.ddr3_addr},
          {v.x_rd, v.x_wr, v.x_addr});
      bus.ddr3_waitrequest = 1'b0;
      tick();
      chk($sformatf("v%0d_deassert", i), {bus.ddr3_read, bus.ddr3_write}, 0);
      bus.ddr3_waitrequest = 1'b1;
      if (v.x_rd) begin
        deliver(int'(v.x_burst), c0, c1, dbad);
        chk($sformatf("v%0d_beats_m0", i), c0, v.m1 ? 0 : int'(v.x_burst));
        chk($sformatf("v%0d_beats_m1", i), c1, v.m1 ? int'(v.x_burst) : 0);
        chk($sformatf("v%0d_beat_data", i), dbad, 0);
      end
    end
    chk("v_orphan", rd_orphan, 0);

    // M1 burst of 8 then M0 read: beats route in order, no cross-routing
    do_reset();
    bus.ddr3_waitrequest = 1'b0;
    bus.m1_address = 29'h1000; bus.m1_burstcount = 8'd8; bus.m1_read = 1'b1;
    wait_grant(1'b1, 10, ok);
    chk("ord_m1_grant", ok, 1);
    bus.m1_read = 1'b0;
    bus.m0_address = 29'h2000; bus.m0_read = 1'b1;
    wait_grant(1'b0, 10, ok);
    chk("ord_m0_grant", ok, 1);
    bus.m0_read = 1'b0;
    tick(); tick();
    deliver(8, c0, c1, dbad);
    chk("ord_first8", {c0[15:0], c1[15:0], dbad[15:0]}, {16'd0, 16'd8, 16'd0});
    deliver(1, c0, c1, dbad);
    chk("ord_last1", {c0[15:0], c1[15:0], dbad[15:0]}, {16'd1, 16'd0, 16'd0});

    // Round-robin then urgent, both masters requesting continuously
    do_reset();
    bus.ddr3_waitrequest = 1'b0;
    bus.m0_address = 29'h10; bus.m0_read = 1'b1;
    bus.m1_address = 29'h20; bus.m1_burstcount = 8'd1; bus.m1_read = 1'b1;
    g = 0; both = 0;
    for (int c = 0; c < 60 && g < 10; c++) begin
      if (g == 6) bus.m1_urgent = 1'b1;
      tick();
      if (!bus.m0_waitrequest && !bus.m1_waitrequest) both++;
      if (!bus.m0_waitrequest) begin seq[g] = 1'b0; g++; end
      else if (!bus.m1_waitrequest) begin seq[g] = 1'b1; g++; end
    end
    chk("rr_grants", g, 10);
    chk("rr_both_low", both, 0);
    for (int i = 0; i < 10; i++)
      chk($sformatf("rr_seq%0d", i), (i < g) ? seq[i] : 1'bx, (i < 6) ? 1'(i % 2) : 1'b1);

    // Write held behind 4 outstanding read beats; M1 read waits for the write
    do_reset();
    bus.ddr3_waitrequest = 1'b0;
    bus.m1_address = 29'h3000; bus.m1_burstcount = 8'd4; bus.m1_read = 1'b1;
    wait_grant(1'b1, 10, ok);
    chk("war_rd_grant", ok, 1);
    bus.m1_read = 1'b0;
    tick();
    bus.m0_address = 29'h4444; bus.m0_writedata = 64'h5555_AAAA; bus.m0_byteenable = 8'hFF;
    bus.m0_write = 1'b1;
    bus.m1_address = 29'h5000; bus.m1_burstcount = 8'd1; bus.m1_read = 1'b1;
    viol = 0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        if (bus.ddr3_write || !bus.m0_waitrequest || !bus.m1_waitrequest) viol++;
      end
      bus.ddr3_readdatavalid = 1'b1;
      tick();
      bus.ddr3_readdatavalid = 1'b0;
    end
    chk("war_stall_violations", viol, 0);
    wait_grant(1'b0, 6, ok);
    chk("war_wr_grant", ok, 1);
    chk("war_wr_cmd", {bus.ddr3_write, bus.ddr3_read, bus.ddr3_addr}, {2'b10, 29'h4444});
    bus.m0_write = 1'b0;
    wait_grant(1'b1, 8, ok);
    chk("war_m1_after", ok, 1);
    chk("war_m1_cmd", {bus.ddr3_read, bus.ddr3_addr}, {1'b1, 29'h5000});
    bus.m1_read = 1'b0;

    // Sixteen outstanding bursts fill the tag FIFO; the 17th waits for a completion
    do_reset();
    bus.ddr3_waitrequest = 1'b0;
    bus.m1_address = 29'h6000; bus.m1_burstcount = 8'd2; bus.m1_read = 1'b1;
    g = 0;
    for (int c = 0; c < 80 && g < 16; c++) begin
      tick();
      if (!bus.m1_waitrequest) g++;
    end
    chk("full_16_grants", g, 16);
    viol = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!bus.m1_waitrequest) viol++;
    end
    chk("full_17th_blocked", viol, 0);
    deliver(2, c0, c1, dbad);
    chk("full_burst_beats", {c0[15:0], c1[15:0], dbad[15:0]}, {16'd0, 16'd2, 16'd0});
    wait_grant(1'b1, 6, ok);
    chk("full_17th_granted", ok, 1);
    bus.m1_read = 1'b0;

    // Reset with two reads outstanding: late beats become orphans
    do_reset();
    bus.ddr3_waitrequest = 1'b0;
    bus.m1_address = 29'h7000; bus.m1_burstcount = 8'd1; bus.m1_read = 1'b1;
    g = 0;
    for (int c = 0; c < 20 && g < 2; c++) begin
      tick();
      if (!bus.m1_waitrequest) g++;
    end
    chk("orph_2_grants", g, 2);
    bus.m1_read = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("orph_pre", rd_orphan, 0);
    deliver(2, c0, c1, dbad);
    chk("orph_no_valid", {c0[15:0], c1[15:0]}, 0);
    chk("orph_flag", rd_orphan, 1);
    tick();
    chk("orph_sticky", rd_orphan, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
